// File: rtl/shift_frame_engine.sv
// ---------------------------------------------------------------------------
// shift_frame_engine
//
// Frame serializer/deserializer around a universal shift register. A WIDTH-bit
// word is loaded over a valid/ready handshake. It is then shifted STEP bits per
// enabled cycle, left or right, in logical, rotate or arithmetic mode. After
// WIDTH/STEP shifts the resulting word is offered on a valid/ready output port.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   cfg_dir           0 = left (MSB first out), 1 = right (LSB first out)
//   cfg_mode          00 logical, 01 rotate, 10 arithmetic, 11 logical
//                     (dir and mode are latched at load)
//   in_valid/in_ready load handshake; in_ready only in IDLE
//   in_data           word to load
//   shift_en          permits a shift this cycle
//   serial_in         fill bits for logical mode
//   serial_out        bits leaving the register on the next shift
//   serial_out_valid  a shift happens at the next edge
//   out_valid/out_ready  completed-frame handshake
//   out_data          the shift register contents
//   busy              engine is not idle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// SHIFT | shifting one STEP per cycle with shift_en, counting to N
// HOLD  | frame complete; out_valid high until out_ready
// ---------------------------------------------------------------------------
module shift_frame_engine #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_dir,
   input  logic [1:0]       cfg_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             shift_en,
   input  logic [STEP-1:0]  serial_in,
   output logic [STEP-1:0]  serial_out,
   output logic             serial_out_valid,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] MODE_ROTATE = 2'b01;
   localparam logic [1:0] MODE_ARITH  = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] data_q;
   logic [CW-1:0]    cnt_q;
   logic             dir_q;
   logic [1:0]       mode_q;

   logic             load;
   logic             do_shift;
   logic             last_shift;
   logic [STEP-1:0]  leaving;
   logic [STEP-1:0]  fill;
   logic [WIDTH-1:0] fill_ext;
   logic [WIDTH-1:0] shifted;

   // Bits that leave the register on the next shift; also the rotate fill.
   always_comb begin
      leaving = dir_q ? data_q[STEP-1:0] : data_q[WIDTH-1 -: STEP];
   end

   // Arithmetic left deliberately falls through to the logical fill.
   always_comb begin
      fill = serial_in;
      case (mode_q)
         MODE_ROTATE: fill = leaving;
         MODE_ARITH:  if (dir_q) fill = {STEP{data_q[WIDTH-1]}};
         default:     fill = serial_in;
      endcase
   end

   // Shift operators instead of part-selects keep STEP == WIDTH legal: the
   // shifted-out register becomes all zeros and the fill replaces it.
   always_comb begin
      fill_ext = WIDTH'(fill);
      if (dir_q) begin
         shifted = (data_q >> STEP) | (fill_ext << (WIDTH - STEP));
      end else begin
         shifted = (data_q << STEP) | fill_ext;
      end
   end

   always_comb begin
      load       = (state_q == IDLE) && in_valid;
      do_shift   = (state_q == SHIFT) && shift_en;
      last_shift = do_shift && (cnt_q == CW'(N - 1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)   state_d = SHIFT;
         SHIFT:   if (last_shift) state_d = HOLD;
         HOLD:    if (out_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
         dir_q  <= 1'b0;
         mode_q <= 2'b00;
      end else if (load) begin
         data_q <= in_data;
         cnt_q  <= '0;
         dir_q  <= cfg_dir;
         mode_q <= cfg_mode;
      end else if (do_shift) begin
         data_q <= shifted;
         cnt_q  <= cnt_q + CW'(1);
      end
   end

   always_comb begin
      in_ready         = (state_q == IDLE);
      busy             = (state_q != IDLE);
      out_valid        = (state_q == HOLD);
      serial_out_valid = do_shift;
      serial_out       = leaving;
      out_data         = data_q;
   end

endmodule

// File: tb/tb_shift_frame_engine.sv
module tb_shift_frame_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   always #5 clk = ~clk;

   // STEP = 1 instance
   logic       cfg_dir, in_valid, in_ready, shift_en, serial_out_valid;
   logic       out_valid, out_ready, busy;
   logic [1:0] cfg_mode;
   logic [7:0] in_data, out_data;
   logic [0:0] serial_in, serial_out;

   // STEP = 2 instance
   logic       s2_cfg_dir, s2_in_valid, s2_in_ready, s2_shift_en, s2_serial_out_valid;
   logic       s2_out_valid, s2_out_ready, s2_busy;
   logic [1:0] s2_cfg_mode, s2_serial_in, s2_serial_out;
   logic [7:0] s2_in_data, s2_out_data;

   int vectors = 0;
   int errors  = 0;

   shift_frame_engine #(.WIDTH(8), .STEP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .cfg_dir(cfg_dir), .cfg_mode(cfg_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .shift_en(shift_en), .serial_in(serial_in), .serial_out(serial_out),
      .serial_out_valid(serial_out_valid), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   shift_frame_engine #(.WIDTH(8), .STEP(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .cfg_dir(s2_cfg_dir), .cfg_mode(s2_cfg_mode),
      .in_valid(s2_in_valid), .in_ready(s2_in_ready), .in_data(s2_in_data),
      .shift_en(s2_shift_en), .serial_in(s2_serial_in), .serial_out(s2_serial_out),
      .serial_out_valid(s2_serial_out_valid), .out_valid(s2_out_valid),
      .out_ready(s2_out_ready), .out_data(s2_out_data), .busy(s2_busy)
   );

   // Whole-frame reference: after 8 one-bit shifts every original bit has left
   // exactly once, so the result depends only on mode and the fill sequence.
   // fillv[k] is the fill bit offered on the k-th shift.
   function automatic logic [7:0] model_final(input logic [7:0] d, input logic dir,
                                              input logic [1:0] mode, input logic [7:0] fillv);
      logic [7:0] r;
      if (mode == 2'b01) return d;
      if (mode == 2'b10 && dir) return {8{d[7]}};
      if (dir) return fillv;
      for (int k = 0; k < 8; k++) r[7-k] = fillv[k];
      return r;
   endfunction

   function automatic logic model_out(input logic [7:0] d, input logic dir, input int k);
      return dir ? d[k] : d[7-k];
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [7:0] d, input logic dir, input logic [1:0] mode,
                            input logic [7:0] fillv, input int stall_after, input int stall_len,
                            input int hold_len, input string tag);
      logic [7:0] exp;
      int cyc, k, stalls;
      logic stalling;
      exp = model_final(d, dir, mode, fillv);
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL %s idle in_ready got %b want 1", tag, in_ready);
      end
      vectors++;
      in_data = d; cfg_dir = dir; cfg_mode = mode; in_valid = 1'b1; shift_en = 1'b0;
      next_cycle();
      cyc = 0; k = 0; stalls = 0;
      while (k < 8 && cyc < 100) begin
         stalling  = (k == stall_after) && (stalls < stall_len);
         shift_en  = !stalling;
         serial_in = fillv[k];
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         cfg_dir   = 1'($urandom_range(0, 1));
         cfg_mode  = 2'($urandom_range(0, 3));
         out_ready = 1'($urandom_range(0, 1));
         #1;
         vectors++;
         if (busy !== 1'b1 || out_valid !== 1'b0 || serial_out_valid !== !stalling) begin
            errors++;
            $display("FAIL %s shift%0d status busy=%b out_valid=%b sov=%b want 1 0 %b",
                     tag, k, busy, out_valid, serial_out_valid, !stalling);
         end
         if (!stalling) begin
            vectors++;
            if (serial_out !== model_out(d, dir, k)) begin
               errors++;
               $display("FAIL %s serial_out%0d got %b want %b", tag, k, serial_out,
                        model_out(d, dir, k));
            end
         end
         next_cycle();
         cyc++;
         if (stalling) stalls++; else k++;
      end
      shift_en = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b1 || cyc != 8 + stall_len) begin
         errors++;
         $display("FAIL %s completion out_valid=%b after %0d cycles want 1 after %0d",
                  tag, out_valid, cyc, 8 + stall_len);
      end
      vectors++;
      if (out_data !== exp || serial_out !== (dir ? exp[0] : exp[7])) begin
         errors++;
         $display("FAIL %s out_data got %h want %h", tag, out_data, exp);
      end
      for (int h = 0; h < hold_len; h++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom);
         cfg_dir  = ~cfg_dir;
         cfg_mode = 2'($urandom_range(0, 3));
         next_cycle();
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
            errors++;
            $display("FAIL %s hold%0d out_valid=%b in_ready=%b out_data=%h want 1 0 %h",
                     tag, h, out_valid, in_ready, out_data, exp);
         end
      end
      out_ready = 1'b1;
      next_cycle();
      out_ready = 1'b0; in_valid = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release in_ready=%b out_valid=%b busy=%b want 1 0 0",
                  tag, in_ready, out_valid, busy);
      end
   endtask

   task automatic run_frame2(input logic [7:0] d, input logic dir, input logic [1:0] mode,
                             input logic [7:0] fillv, input string tag);
      logic [7:0] exp, t;
      int cyc;
      if (mode == 2'b01) exp = d;
      else if (dir) exp = fillv;
      else exp = {fillv[1:0], fillv[3:2], fillv[5:4], fillv[7:6]};
      s2_in_data = d; s2_cfg_dir = dir; s2_cfg_mode = mode; s2_in_valid = 1'b1;
      s2_shift_en = 1'b0; s2_out_ready = 1'b0;
      next_cycle();
      s2_in_valid = 1'b0;
      cyc = 0;
      for (int k = 0; k < 4; k++) begin
         s2_shift_en  = 1'b1;
         s2_serial_in = fillv[2*k +: 2];
         s2_cfg_dir   = ~dir;
         #1;
         t = dir ? (d >> (2*k)) : (d >> (6 - 2*k));
         vectors++;
         if (s2_serial_out !== t[1:0] || s2_serial_out_valid !== 1'b1 || s2_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s serial_out%0d got %b sov=%b ov=%b want %b 1 0", tag, k,
                     s2_serial_out, s2_serial_out_valid, s2_out_valid, t[1:0]);
         end
         next_cycle();
         cyc++;
      end
      s2_shift_en = 1'b0;
      #1;
      vectors++;
      if (s2_out_valid !== 1'b1 || s2_out_data !== exp) begin
         errors++;
         $display("FAIL %s frame out_valid=%b out_data=%h after %0d want 1 %h", tag,
                  s2_out_valid, s2_out_data, cyc, exp);
      end
      s2_out_ready = 1'b1;
      next_cycle();
      s2_out_ready = 1'b0;
      #1;
      vectors++;
      if (s2_in_ready !== 1'b1 || s2_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release in_ready=%b busy=%b want 1 0", tag, s2_in_ready, s2_busy);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
          serial_out_valid !== 1'b0 || out_data !== 8'h00 || serial_out !== 1'b0) begin
         errors++;
         $display("FAIL %s ir=%b busy=%b ov=%b sov=%b od=%h so=%b want 1 0 0 0 00 0", tag,
                  in_ready, busy, out_valid, serial_out_valid, out_data, serial_out);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cfg_dir = 0; cfg_mode = 0; in_valid = 0; in_data = 0; shift_en = 1; serial_in = 0;
      out_ready = 0;
      s2_cfg_dir = 0; s2_cfg_mode = 0; s2_in_valid = 0; s2_in_data = 0; s2_shift_en = 0;
      s2_serial_in = 0; s2_out_ready = 0;
      #2;
      check_reset_outputs("reset");
      vectors++;
      if (s2_in_ready !== 1'b1 || s2_out_data !== 8'h00 || s2_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_step2 ir=%b od=%h busy=%b want 1 00 0", s2_in_ready,
                  s2_out_data, s2_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      shift_en = 1'b0;
      next_cycle();
   endtask

   task automatic test_left_logical();
      run_frame(8'hA5, 1'b0, 2'b00, 8'hCD, -1, 0, 0, "left_logical");
   endtask

   task automatic test_step2_rotate();
      run_frame2(8'h81, 1'b1, 2'b01, 8'h5A, "step2_rotate");
      for (int i = 0; i < 6; i++)
         run_frame2(8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
                    8'($urandom), "step2_random");
   endtask

   task automatic test_arith();
      run_frame(8'h90, 1'b1, 2'b10, 8'($urandom), -1, 0, 0, "arith_neg");
      run_frame(8'h70, 1'b1, 2'b10, 8'($urandom), -1, 0, 0, "arith_pos");
      run_frame(8'h90, 1'b1, 2'b11, 8'h00, -1, 0, 0, "mode11_logical");
      run_frame(8'hC3, 1'b0, 2'b10, 8'h96, -1, 0, 0, "arith_left");
   endtask

   task automatic test_stall();
      run_frame(8'hA5, 1'b0, 2'b00, 8'hCD, 3, 3, 0, "stall");
   endtask

   task automatic test_back_to_back_hold();
      run_frame(8'h5E, 1'b1, 2'b01, 8'($urandom), -1, 0, 5, "hold_backpressure");
      run_frame(8'hA1, 1'b1, 2'b10, 8'($urandom), -1, 0, 0, "next_frame_cfg");
   endtask

   task automatic test_reset_midframe();
      in_data = 8'hC3; cfg_dir = 1'b0; cfg_mode = 2'b00; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0; shift_en = 1'b1; serial_in = 1'b1;
      for (int i = 0; i < 4; i++) next_cycle();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_midframe");
      @(negedge clk);
      rst_n = 1'b1;
      shift_en = 1'b0;
      next_cycle();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_aborted out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      run_frame(8'h3C, 1'b0, 2'b00, 8'($urandom), -1, 0, 0, "after_reset");
   endtask

   task automatic test_random();
      int sa, sl;
      for (int i = 0; i < 12; i++) begin
         sa = $urandom_range(0, 7);
         sl = $urandom_range(0, 3);
         run_frame(8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   8'($urandom), sa, sl, $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      test_reset();
      test_left_logical();
      test_step2_rotate();
      test_arith();
      test_stall();
      test_back_to_back_hold();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
